// File: rtl/clk_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_gen_pkg                                                     |
// | Purpose  : Shared encodings for the multi-channel clock generator:         |
// |            mode codes, per-channel FSM states and the minimum divider.     |
// | Macro    : CLK_GEN_PHASE_EN (used by clk_gen_channel / clk_gen_multi)      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package clk_gen_pkg;

  // Mode field per channel; 2'b11 is reserved and behaves as OFF.
  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_AUTO  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;

  // Smallest divider that still yields a high and a low phase.
  localparam int MIN_DIV = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/clk_gen_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_gen_channel                                                 |
// | Purpose  : One clock-generator channel: FSM (IDLE/RUN/BURST), shadowed     |
// |            divider/high-time/burst-length, period and burst counters.      |
// | Ports    : clk, reset (async, active low), mode[1:0], out_enable,          |
// |            divider, high_time, burst_len, start, sync, [phase],            |
// |            clk_o, tick_o, busy, done                                       |
// | Macro    : CLK_GEN_PHASE_EN adds the phase input (counter preload).        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module clk_gen_channel
  import clk_gen_pkg::*;
#(
  parameter int COUNTER_BITS = 32,
  parameter int BURST_BITS   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    out_enable,
  input  logic [COUNTER_BITS-1:0] divider,
  input  logic [COUNTER_BITS-1:0] high_time,
  input  logic [BURST_BITS-1:0]   burst_len,
  input  logic                    start,
  input  logic                    sync,
`ifdef CLK_GEN_PHASE_EN
  input  logic [COUNTER_BITS-1:0] phase,
`endif
  output logic                    clk_o,
  output logic                    tick_o,
  output logic                    busy,
  output logic                    done
);

  localparam logic [COUNTER_BITS-1:0] C_CNT_ONE = COUNTER_BITS'(1);
  localparam logic [COUNTER_BITS-1:0] C_MIN_DIV = COUNTER_BITS'(MIN_DIV);
  localparam logic [BURST_BITS-1:0]   C_PER_ONE = BURST_BITS'(1);
  localparam logic [BURST_BITS:0]     C_EXT_ONE = (BURST_BITS+1)'(1);

  state_t                  r_state;
  logic [COUNTER_BITS-1:0] r_cnt;
  logic [BURST_BITS-1:0]   r_periods;
  logic [COUNTER_BITS-1:0] r_d_sh;
  logic [COUNTER_BITS-1:0] r_h_sh;
  logic [BURST_BITS-1:0]   r_n_sh;
  logic                    r_clk;
  logic                    r_tick;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_done_pend;

  logic [COUNTER_BITS-1:0] w_d_eff;
  logic [COUNTER_BITS-1:0] w_h_eff;
  logic [COUNTER_BITS-1:0] w_start_cnt;
  logic                    w_active;
  logic                    w_boundary;
  logic                    w_burst_end;

  // Clamp the live config so the shadow registers always hold 1 <= H <= D-1.
  assign w_d_eff = (divider < C_MIN_DIV) ? C_MIN_DIV : divider;
  assign w_h_eff = (high_time == '0)      ? (w_d_eff >> 1) :
                   (high_time >= w_d_eff) ? (w_d_eff - C_CNT_ONE) : high_time;

  assign w_active   = (r_state != ST_IDLE);
  assign w_boundary = (r_cnt == r_d_sh - C_CNT_ONE);
  // ">=" rather than "==" so a burst length reduced mid-burst still terminates.
  assign w_burst_end = (r_state == ST_BURST) && w_boundary &&
                       (({1'b0, r_periods} + C_EXT_ONE) >= {1'b0, r_n_sh});

`ifdef CLK_GEN_PHASE_EN
  logic [COUNTER_BITS-1:0] w_d_mod;
  // The divider that will be in force after this edge: the freshly clamped
  // one when the shadows reload (leaving IDLE or at a boundary).
  assign w_d_mod     = ((r_state == ST_IDLE) || w_boundary) ? w_d_eff : r_d_sh;
  assign w_start_cnt = phase % w_d_mod;
`else
  assign w_start_cnt = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_periods   <= '0;
      r_d_sh      <= '0;
      r_h_sh      <= '0;
      r_n_sh      <= '0;
      r_clk       <= 1'b0;
      r_tick      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_done_pend <= 1'b0;
    end else begin
      // Outputs trail the counter by one edge so every output is a flop.
      r_clk       <= w_active && (r_cnt < r_h_sh);
      r_tick      <= w_active && (r_cnt == '0);
      r_busy      <= w_active;
      r_done      <= r_done_pend;
      r_done_pend <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_periods <= '0;
          if (mode == MODE_AUTO) begin
            r_state <= ST_RUN;
            r_d_sh  <= w_d_eff;
            r_h_sh  <= w_h_eff;
            r_n_sh  <= burst_len;
            r_cnt   <= w_start_cnt;
          end else if ((mode == MODE_BURST) && start) begin
            if (burst_len == '0) begin
              r_done_pend <= 1'b1;
            end else begin
              r_state <= ST_BURST;
              r_d_sh  <= w_d_eff;
              r_h_sh  <= w_h_eff;
              r_n_sh  <= burst_len;
              r_cnt   <= w_start_cnt;
            end
          end
        end

        default: begin
          if (w_boundary) begin
            r_d_sh <= w_d_eff;
            r_h_sh <= w_h_eff;
            r_n_sh <= burst_len;
          end
          // A completing burst wins over sync; otherwise sync wins over the wrap.
          if (w_burst_end) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_periods   <= '0;
            r_done_pend <= 1'b1;
          end else if (sync) begin
            r_cnt <= w_start_cnt;
          end else if (w_boundary) begin
            r_cnt <= '0;
            if (((r_state == ST_RUN)   && (mode != MODE_AUTO)) ||
                ((r_state == ST_BURST) && (mode != MODE_BURST))) begin
              r_state   <= ST_IDLE;
              r_periods <= '0;
            end else if (r_state == ST_BURST) begin
              r_periods <= r_periods + C_PER_ONE;
            end
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
      endcase
    end
  end

  // out_enable gates only the clock and tick; status flags stay visible.
  assign clk_o  = r_clk  & out_enable;
  assign tick_o = r_tick & out_enable;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: rtl/clk_gen_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_gen_multi                                                   |
// | Purpose  : NUM_CH independent divided-clock / tick generators with         |
// |            OFF, AUTO and counted BURST modes and a common sync restart.    |
// | Ports    : clk, reset (async, active low), mode[2*NUM_CH], out_enable,     |
// |            divider, high_time, burst_len (flattened per channel), start,   |
// |            sync, [phase], clk_o, tick_o, busy, done                        |
// | Macro    : CLK_GEN_PHASE_EN adds phase[NUM_CH*COUNTER_BITS].               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module clk_gen_multi
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int COUNTER_BITS = 32,
  parameter int BURST_BITS   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [2*NUM_CH-1:0]            mode,
  input  logic [NUM_CH-1:0]              out_enable,
  input  logic [NUM_CH*COUNTER_BITS-1:0] divider,
  input  logic [NUM_CH*COUNTER_BITS-1:0] high_time,
  input  logic [NUM_CH*BURST_BITS-1:0]   burst_len,
  input  logic [NUM_CH-1:0]              start,
  input  logic                           sync,
`ifdef CLK_GEN_PHASE_EN
  input  logic [NUM_CH*COUNTER_BITS-1:0] phase,
`endif
  output logic [NUM_CH-1:0]              clk_o,
  output logic [NUM_CH-1:0]              tick_o,
  output logic [NUM_CH-1:0]              busy,
  output logic [NUM_CH-1:0]              done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_gen_channel #(
      .COUNTER_BITS (COUNTER_BITS),
      .BURST_BITS   (BURST_BITS)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .mode       (mode[2*i +: 2]),
      .out_enable (out_enable[i]),
      .divider    (divider[COUNTER_BITS*i +: COUNTER_BITS]),
      .high_time  (high_time[COUNTER_BITS*i +: COUNTER_BITS]),
      .burst_len  (burst_len[BURST_BITS*i +: BURST_BITS]),
      .start      (start[i]),
      .sync       (sync),
`ifdef CLK_GEN_PHASE_EN
      .phase      (phase[COUNTER_BITS*i +: COUNTER_BITS]),
`endif
      .clk_o      (clk_o[i]),
      .tick_o     (tick_o[i]),
      .busy       (busy[i]),
      .done       (done[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_gen_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_clk_gen_multi                                                |
// | Purpose  : Self-checking bench for clk_gen_multi (2 channels). Expected    |
// |            waveforms are built as per-period sample lists from the         |
// |            divider / high-time rules and compared cycle by cycle.          |
// | Macro    : CLK_GEN_PHASE_EN enables the phase-preload scenario.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_clk_gen_multi;

  localparam int NCH = 2;
  localparam int CB  = 32;
  localparam int BB  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [2*NCH-1:0]  mode;
  logic [NCH-1:0]    out_enable;
  logic [NCH*CB-1:0] divider;
  logic [NCH*CB-1:0] high_time;
  logic [NCH*BB-1:0] burst_len;
  logic [NCH-1:0]    start;
  logic              sync;
`ifdef CLK_GEN_PHASE_EN
  logic [NCH*CB-1:0] phase;
`endif
  logic [NCH-1:0]    clk_o;
  logic [NCH-1:0]    tick_o;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    done;

  clk_gen_multi #(
    .NUM_CH       (NCH),
    .COUNTER_BITS (CB),
    .BURST_BITS   (BB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .out_enable (out_enable),
    .divider    (divider),
    .high_time  (high_time),
    .burst_len  (burst_len),
    .start      (start),
    .sync       (sync),
`ifdef CLK_GEN_PHASE_EN
    .phase      (phase),
`endif
    .clk_o      (clk_o),
    .tick_o     (tick_o),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic c;
    logic t;
  } smp_t;
  smp_t exp_q[$];

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Effective divider / high time from the clamping rules.
  function automatic int eff_d(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int eff_h(input int d, input int h);
    int de;
    de = eff_d(d);
    if (h == 0)  return de / 2;
    if (h >= de) return de - 1;
    return h;
  endfunction

  // Append n periods: H high samples then D-H low, tick on the first.
  function automatic void push_periods(input int d, input int h, input int n);
    smp_t s;
    int   de, he;
    de = eff_d(d);
    he = eff_h(d, h);
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < de; k++) begin
        s.c = (k < he);
        s.t = (k == 0);
        exp_q.push_back(s);
      end
    end
  endfunction

  task automatic drain(input int ch, input int n);
    smp_t s;
    for (int k = 0; k < n; k++) begin
      step();
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL model_empty ch=%0d", ch);
      end else begin
        s = exp_q.pop_front();
        chk("clk_o", clk_o[ch], s.c);
        chk("tick_o", tick_o[ch], s.t);
        chk("busy_run", busy[ch], 1'b1);
        chk("done_run", done[ch], 1'b0);
      end
    end
  endtask

  task automatic idle_chk(input int ch, input logic done_exp);
    step();
    chk("idle_clk_o", clk_o[ch], 1'b0);
    chk("idle_tick_o", tick_o[ch], 1'b0);
    chk("idle_busy", busy[ch], 1'b0);
    chk("idle_done", done[ch], done_exp);
  endtask

  task automatic cfg(input int ch, input logic [1:0] m, input int d, input int h, input int n);
    mode[2*ch +: 2]       = m;
    divider[CB*ch +: CB]  = d;
    high_time[CB*ch +: CB] = h;
    burst_len[BB*ch +: BB] = 16'(n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, h, n;
    reset      = 1'b0;
    mode       = '0;
    out_enable = '1;
    divider    = '0;
    high_time  = '0;
    burst_len  = '0;
    start      = '0;
    sync       = 1'b0;
`ifdef CLK_GEN_PHASE_EN
    phase      = '0;
`endif

    // Reset state
    #2;
    for (int c = 0; c < NCH; c++) begin
      chk("rst_clk_o", clk_o[c], 1'b0);
      chk("rst_tick_o", tick_o[c], 1'b0);
      chk("rst_busy", busy[c], 1'b0);
      chk("rst_done", done[c], 1'b0);
    end
    repeat (3) step();
    reset = 1'b1;
    step();

    // AUTO D=4 H=0 -> 1100; switch OFF one cycle into a period
    cfg(0, 2'b01, 4, 0, 0);
    step();
    push_periods(4, 0, 3);
    drain(0, 9);
    cfg(0, 2'b00, 4, 0, 0);
    drain(0, 3);
    idle_chk(0, 1'b0);
    idle_chk(0, 1'b0);

    // AUTO D=5 H=9 -> 11110; then D=1 -> 10 after current period
    cfg(0, 2'b01, 5, 9, 0);
    step();
    push_periods(5, 9, 3);
    drain(0, 10);
    cfg(0, 2'b01, 1, 0, 0);
    push_periods(1, 0, 3);
    drain(0, 11);
    cfg(0, 2'b00, 1, 0, 0);
    push_periods(1, 0, 1);
    drain(0, 2);
    idle_chk(0, 1'b0);

    // AUTO D=6, divider changed to 2 at cnt=2
    cfg(0, 2'b01, 6, 3, 0);
    step();
    push_periods(6, 3, 1);
    drain(0, 2);
    cfg(0, 2'b01, 2, 0, 0);
    push_periods(2, 0, 2);
    drain(0, 8);
    cfg(0, 2'b00, 2, 0, 0);
    push_periods(2, 0, 1);
    drain(0, 2);
    idle_chk(0, 1'b0);

    // BURST D=3 H=1 N=3 with an ignored retrigger
    cfg(0, 2'b10, 3, 1, 3);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    push_periods(3, 1, 3);
    drain(0, 4);
    start[0] = 1'b1;
    drain(0, 1);
    start[0] = 1'b0;
    drain(0, 4);
    idle_chk(0, 1'b1);
    idle_chk(0, 1'b0);
    idle_chk(0, 1'b0);

    // BURST with N=0: no run, single done pulse
    cfg(0, 2'b10, 3, 1, 0);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("n0_busy", busy[0], 1'b0);
    idle_chk(0, 1'b1);
    idle_chk(0, 1'b0);

    // Randomised bursts
    for (int it = 0; it < 6; it++) begin
      d = int'($urandom_range(1, 9));
      h = int'($urandom_range(0, 11));
      n = int'($urandom_range(1, 4));
      cfg(0, 2'b10, d, h, n);
      start[0] = 1'b1;
      step();
      start[0] = 1'b0;
      push_periods(d, h, n);
      drain(0, n * eff_d(d));
      idle_chk(0, 1'b1);
      idle_chk(0, 1'b0);
    end
    cfg(0, 2'b00, 2, 0, 0);
    step();

    // Two channels, offset start, common sync, then out_enable masking
    cfg(0, 2'b01, 4, 2, 0);
    step();
    cfg(1, 2'b01, 6, 3, 0);
    repeat (3) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("sync_clk0", clk_o[0], (k % 4) < 2);
      chk("sync_tick0", tick_o[0], (k % 4) == 0);
      chk("sync_clk1", clk_o[1], (k % 6) < 3);
      chk("sync_tick1", tick_o[1], (k % 6) == 0);
    end
    out_enable[0] = 1'b0;
    #1;
    chk("oe_clk0_now", clk_o[0], 1'b0);
    for (int k = 12; k < 18; k++) begin
      step();
      chk("oe_clk0", clk_o[0], 1'b0);
      chk("oe_tick0", tick_o[0], 1'b0);
      chk("oe_busy0", busy[0], 1'b1);
      chk("oe_clk1", clk_o[1], (k % 6) < 3);
    end
    out_enable[0] = 1'b1;
    cfg(0, 2'b00, 4, 2, 0);
    cfg(1, 2'b00, 6, 3, 0);
    repeat (8) step();
    chk("off_busy0", busy[0], 1'b0);
    chk("off_busy1", busy[1], 1'b0);

    // Asynchronous reset in the middle of a burst
    cfg(0, 2'b10, 3, 1, 5);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (4) step();
    chk("pre_rst_busy", busy[0], 1'b1);
    reset = 1'b0;
    #2;
    for (int c = 0; c < NCH; c++) begin
      chk("arst_clk_o", clk_o[c], 1'b0);
      chk("arst_tick_o", tick_o[c], 1'b0);
      chk("arst_busy", busy[c], 1'b0);
      chk("arst_done", done[c], 1'b0);
    end
    repeat (2) step();
    reset = 1'b1;
    repeat (3) idle_chk(0, 1'b0);
    cfg(0, 2'b00, 3, 1, 0);

`ifdef CLK_GEN_PHASE_EN
    // Phase preload: D=4 H=2 phase=2 -> 00 then 1100 repeating
    phase[CB*0 +: CB] = 2;
    cfg(0, 2'b01, 4, 2, 0);
    step();
    for (int k = 0; k < 2; k++) begin
      step();
      chk("ph_clk0", clk_o[0], 1'b0);
      chk("ph_tick0", tick_o[0], 1'b0);
      chk("ph_busy0", busy[0], 1'b1);
    end
    push_periods(4, 2, 2);
    drain(0, 8);
    cfg(0, 2'b00, 4, 2, 0);
    repeat (6) step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_gen_multi.md
Name: clk_gen_multi

Overview:
- Parametrised, multi-channel successor to the single-channel debug clock divider in the processor-CI controller.
- Each channel derives a gated clock-like output and a single-cycle tick strobe from the system clock.
- Each channel has its own divider, high time and mode: off, free-running auto, or counted N-period burst.
- Sits between the controller's command decoder and the processor-under-test clock/enable inputs.

Parameters:
- NUM_CH, 2, number of independent channels (1..8).
- COUNTER_BITS, 32, width of the divider, high-time and period counters.
- BURST_BITS, 16, width of the burst period count.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- mode  input  2*NUM_CH  per channel: 00 OFF, 01 AUTO, 10 BURST, 11 OFF (reserved).
- out_enable  input  NUM_CH  per channel; 0 forces clk_o low and tick_o low. Counters keep running.
- divider  input  NUM_CH*COUNTER_BITS  period D in clk cycles.
- high_time  input  NUM_CH*COUNTER_BITS  high cycles H per period.
- burst_len  input  NUM_CH*BURST_BITS  number of periods N in BURST mode.
- start  input  NUM_CH  level-sampled burst trigger.
- sync  input  1  restarts every running channel at cnt=0 on the next cycle.
- clk_o  output  NUM_CH  divided clock outputs, registered.
- tick_o  output  NUM_CH  one-cycle strobe on each period start.
- busy  output  NUM_CH  channel in RUN or BURST state.
- done  output  NUM_CH  one-cycle pulse when a burst completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - All channels go to IDLE with cnt=0 and periods=0.
  - Shadow config registers clear to 0.
  - Outputs clk_o, tick_o, busy and done are all 0.
- Arithmetic rules, applied when config is loaded into shadow registers:
  - D<2 is treated as D=2.
  - H=0 becomes floor(D/2).
  - H>=D is clamped to D-1.
  - The effective H is always between 1 and D-1.
- Period generation:
  - cnt counts 0..D-1 and wraps to 0.
  - Registered clk_o = (cnt < H).
  - tick_o = 1 in the cycle clk_o rises (cnt==0 on entry).
- Config shadowing:
  - divider, high_time and burst_len are latched into shadow registers only on leaving IDLE, or when cnt==D-1 (period boundary).
  - Mid-period changes never shorten or glitch the current period.
- Per-channel FSM:
  - IDLE: cnt held at 0, clk_o=0.
    - mode=AUTO → RUN.
    - mode=BURST and start=1 → BURST, with periods=0.
    - BURST with N=0 → stays IDLE and pulses done for 1 cycle.
  - RUN: free-running.
    - If mode is no longer AUTO at the period boundary (cnt==D-1) → IDLE.
    - The current period always completes.
  - BURST: periods increments at each cnt==D-1.
    - When periods reaches N-1 at the boundary → IDLE, with done=1 for the next cycle.
    - If mode leaves BURST, the burst aborts at the next boundary → IDLE with no done.
    - start while in BURST is ignored; no retrigger.
- Latency: state transition at edge t → clk_o=1, tick_o=1, busy=1 from edge t+1.
- sync=1:
  - Every channel in RUN/BURST reloads cnt=0 on the next edge (clk_o high, tick_o pulses).
  - Burst period counts are unchanged.
  - IDLE channels ignore sync.
  - sync takes priority over a simultaneous boundary wrap, except that a burst completing on that edge still completes.
- out_enable:
  - Masks clk_o and tick_o combinationally after the register.
  - Does not mask busy or done.
- Reset asserted mid-burst: immediate return to IDLE, no done.

Optional Feature:
- Macro: CLK_GEN_PHASE_EN.
- Defined:
  - Adds input phase (NUM_CH*COUNTER_BITS).
  - On leaving IDLE and on sync, cnt preloads to phase mod D instead of 0.
  - tick_o fires only when cnt passes 0.
  - clk_o follows cnt<H from the first cycle.
- Undefined: no phase port; cnt always starts at 0.

Decomposition:
- Package clk_gen_pkg holds:
  - mode encodings MODE_OFF / MODE_AUTO / MODE_BURST;
  - state encodings ST_IDLE / ST_RUN / ST_BURST;
  - the min-divider constant 2.
- One sub-module, clk_gen_channel:
  - contains one channel's FSM, shadow registers, counters and clamping;
  - the top generates NUM_CH instances and slices the flattened buses.

Test Plan:
- AUTO, D=4, H=0: clk_o pattern 1100 repeating from the cycle after mode is set; tick_o every 4 cycles; busy=1.
- AUTO, D=5, H=9: H clamps to 4, pattern 11110. D=1: behaves as D=2, H=1, pattern 10.
- BURST, D=3, H=1, N=3, start for 1 cycle: exactly three 100 periods; done pulses once on the cycle after the 9th; busy falls with done; a second start during the burst is ignored.
- AUTO D=6 running; change divider to 2 at cnt=2: current 6-cycle period completes, then 2-cycle periods. Mode set to OFF mid-period: period finishes, then clk_o=0 and busy=0.
- Two channels at D=4 and D=6, offset start; sync pulse: both show tick_o on the same cycle. out_enable[0]=0 silences ch0 outputs while busy[0] stays 1.
- reset driven low mid-burst (asynchronous, between edges): all outputs 0 immediately, no done. With CLK_GEN_PHASE_EN, D=4, H=2, phase=2: first pattern 00 then 1100 repeating.
